// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer: collects DATA_W accepted serial bits into one word
// and presents it on a registered valid/ready output with one word of back-pressure buffering.
module serial_to_parallel #(
  parameter int DATA_W    = 4,
  parameter int COUNTLEN  = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: a bit/word moves on a rising edge where valid && ready; ready never
  // depends on valid, and a raised valid holds its data stable until it is taken.
  input  logic              s_valid_i,
  input  logic              s_data_i,
  output logic              s_ready_o,
  output logic              p_valid_o,
  output logic [DATA_W-1:0] p_data_o,
  input  logic              p_ready_i,
  output logic              dbg_state_o
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam logic [COUNTLEN-1:0] LAST_CNT = COUNTLEN'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [COUNTLEN-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic                p_valid_q, p_valid_d;

  logic                accept;
  logic                out_xfer;
  logic                last_bit;
  logic [COUNTLEN-1:0] pos;
  logic [DATA_W-1:0]   asm_bit;

  assign s_ready_o   = (state_q == COLLECT);
  assign p_valid_o   = p_valid_q;
  assign p_data_o    = p_data_q;
  assign dbg_state_o = state_q;

  assign accept   = s_valid_i && s_ready_o;
  assign out_xfer = p_valid_q && p_ready_i;
  assign last_bit = (cnt_q == LAST_CNT);
  assign pos      = (MSB_FIRST != 0) ? (LAST_CNT - cnt_q) : cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    p_data_d  = p_data_q;
    p_valid_d = p_valid_q;
    asm_bit   = asm_q;

    // Assembly word with the incoming bit already merged in at its position.
    for (int i = 0; i < DATA_W; i++) begin
      if (pos == COUNTLEN'(i)) begin
        asm_bit[i] = s_data_i;
      end
    end

    if (out_xfer) begin
      p_valid_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (last_bit) begin
            cnt_d = '0;
            if (!p_valid_q || out_xfer) begin
              p_data_d  = asm_bit;
              p_valid_d = 1'b1;
              asm_d     = '0;
            end else begin
              // Output slot still occupied: park the finished word and stall input.
              asm_d   = asm_bit;
              state_d = FULL;
            end
          end else begin
            cnt_d = cnt_q + COUNTLEN'(1);
            asm_d = asm_bit;
          end
        end
      end
      FULL: begin
        if (out_xfer) begin
          p_data_d  = asm_q;
          p_valid_d = 1'b1;
          asm_d     = '0;
          state_d   = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      asm_q     <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: LSB-first and MSB-first instances share one stimulus stream,
// each checked by a bit-list reference model and an expected-word queue.
module tb_serial_to_parallel;

  localparam int DATA_W = 4;

  logic clk;
  logic reset;
  logic s_valid_i;
  logic s_data_i;
  logic p_ready_i;
  logic rand_ready;

  logic              s_ready_l, s_ready_m;
  logic              p_valid_l, p_valid_m;
  logic [DATA_W-1:0] p_data_l, p_data_m;
  logic              dbg_l, dbg_m;

  int chk_cnt;
  int pass_cnt;
  int stall_cnt;

  logic [DATA_W-1:0] exp_l[$];
  logic [DATA_W-1:0] exp_m[$];
  logic              bits_l[$];
  logic              bits_m[$];

  serial_to_parallel #(.DATA_W(DATA_W), .COUNTLEN(2), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_l), .p_valid_o(p_valid_l), .p_data_o(p_data_l),
    .p_ready_i(p_ready_i), .dbg_state_o(dbg_l)
  );

  serial_to_parallel #(.DATA_W(DATA_W), .COUNTLEN(2), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_m), .p_valid_o(p_valid_m), .p_data_o(p_data_m),
    .p_ready_i(p_ready_i), .dbg_state_o(dbg_m)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    s_valid_i = 1'b1;
    s_data_i  = b;
    @(negedge clk);
    while (!s_ready_l && n < 200) begin
      @(negedge clk);
      n++;
    end
    stall_cnt += n;
    if (!s_ready_l) chk("send_timeout", 32'(s_ready_l), 32'd1);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic send_word_lsb(input logic [DATA_W-1:0] w);
    for (int i = 0; i < DATA_W; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) p_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: reference model gathers accepted bits and forms words arithmetically.
  logic              mon_en;
  logic              prv_v_l, prv_r, prv_v_m;
  logic [DATA_W-1:0] prv_d_l, prv_d_m;

  initial begin
    logic [DATA_W-1:0] w;
    mon_en  = 1'b0;
    prv_v_l = 1'b0;
    prv_v_m = 1'b0;
    prv_r   = 1'b0;
    prv_d_l = '0;
    prv_d_m = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_en = 1'b1;
        bits_l.delete();
        bits_m.delete();
        exp_l.delete();
        exp_m.delete();
        prv_v_l = 1'b0;
        prv_v_m = 1'b0;
      end else if (mon_en) begin
        if (prv_v_l && !prv_r) begin
          chk("hold_valid_l", 32'(p_valid_l), 32'd1);
          chk("hold_data_l", 32'(p_data_l), 32'(prv_d_l));
        end
        if (prv_v_m && !prv_r) begin
          chk("hold_valid_m", 32'(p_valid_m), 32'd1);
          chk("hold_data_m", 32'(p_data_m), 32'(prv_d_m));
        end
        if (p_valid_l && p_ready_i) begin
          if (exp_l.size() == 0) chk("spurious_l", 32'(exp_l.size()), 32'd1);
          else chk("word_l", 32'(p_data_l), 32'(exp_l.pop_front()));
        end
        if (p_valid_m && p_ready_i) begin
          if (exp_m.size() == 0) chk("spurious_m", 32'(exp_m.size()), 32'd1);
          else chk("word_m", 32'(p_data_m), 32'(exp_m.pop_front()));
        end
        if (s_valid_i && s_ready_l) begin
          bits_l.push_back(s_data_i);
          if (bits_l.size() == DATA_W) begin
            w = '0;
            for (int i = 0; i < DATA_W; i++) w = w | (DATA_W'(bits_l[i]) << i);
            exp_l.push_back(w);
            bits_l.delete();
          end
        end
        if (s_valid_i && s_ready_m) begin
          bits_m.push_back(s_data_i);
          if (bits_m.size() == DATA_W) begin
            w = '0;
            for (int i = 0; i < DATA_W; i++) w = w | (DATA_W'(bits_m[i]) << (DATA_W - 1 - i));
            exp_m.push_back(w);
            bits_m.delete();
          end
        end
        prv_v_l = p_valid_l;
        prv_v_m = p_valid_m;
        prv_d_l = p_data_l;
        prv_d_m = p_data_m;
        prv_r   = p_ready_i;
      end
    end
  end

  // Main stimulus
  initial begin
    chk_cnt    = 0;
    pass_cnt   = 0;
    stall_cnt  = 0;
    rand_ready = 1'b0;
    p_ready_i  = 1'b1;
    s_data_i   = 1'b1;
    s_valid_i  = 1'b1;
    reset      = 1'b1;

    // Reset held with a bit offered
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_l", 32'(p_valid_l), 32'd0);
    chk("rst_data_l", 32'(p_data_l), 32'd0);
    chk("rst_valid_m", 32'(p_valid_m), 32'd0);
    chk("rst_data_m", 32'(p_data_m), 32'd0);
    reset     = 1'b0;
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(s_ready_l), 32'd1);
    chk("rst_no_word", 32'(p_valid_l), 32'd0);
    @(posedge clk);
    #1;

    // Single word, latency and one-cycle pulse
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    chk("lat_valid_l", 32'(p_valid_l), 32'd1);
    chk("lat_data_l", 32'(p_data_l), 32'hB);
    chk("lat_valid_m", 32'(p_valid_m), 32'd1);
    chk("lat_data_m", 32'(p_data_m), 32'hD);
    @(negedge clk);
    chk("pulse_end_l", 32'(p_valid_l), 32'd0);
    chk("pulse_end_m", 32'(p_valid_m), 32'd0);
    @(posedge clk);
    #1;

    // Continuous stream, no input stalls
    stall_cnt = 0;
    send_word_lsb(4'hB);
    send_word_lsb(4'h6);
    send_word_lsb(4'h3);
    chk("stream_no_stall", 32'(stall_cnt), 32'd0);
    idle(3);

    // Back-pressure: two words buffered, input stalls
    p_ready_i = 1'b0;
    send_word_lsb(4'hA);
    send_word_lsb(4'h5);
    @(negedge clk);
    chk("full_ready", 32'(s_ready_l), 32'd0);
    chk("full_state", 32'(dbg_l), 32'd1);
    s_valid_i = 1'b1;
    s_data_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_block", 32'(s_ready_l), 32'd0);
    end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    p_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_first_l", 32'(p_data_l), 32'hA);
    chk("bp_first_m", 32'(p_data_m), 32'h5);
    @(negedge clk);
    chk("bp_second_v", 32'(p_valid_l), 32'd1);
    chk("bp_second_l", 32'(p_data_l), 32'h5);
    chk("bp_second_m", 32'(p_data_m), 32'hA);
    chk("bp_ready", 32'(s_ready_l), 32'd1);
    idle(2);

    // Gapped input
    for (int i = 0; i < DATA_W; i++) begin
      logic [DATA_W-1:0] w9;
      w9 = 4'h9;
      send_bit(w9[i]);
      idle($urandom_range(0, 3));
    end
    @(negedge clk);
    chk("gap_data_l", 32'(p_data_l), 32'h9);
    chk("gap_data_m", 32'(p_data_m), 32'h9);
    @(posedge clk);
    #1;

    // Reset mid-word
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk);
    chk("rstmid_valid", 32'(p_valid_l), 32'd1);
    chk("rstmid_data_l", 32'(p_data_l), 32'h6);
    chk("rstmid_data_m", 32'(p_data_m), 32'h6);
    @(posedge clk);
    #1;

    // Random stream with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    #1;
    p_ready_i = 1'b1;
    idle(20);
    chk("drain_l", 32'(exp_l.size()), 32'd0);
    chk("drain_m", 32'(exp_m.size()), 32'd0);
    chk("final_valid", 32'(p_valid_l), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
